// File: rtl/sum_match_scanner.sv
// Sequential (a+b)==c matcher: scans a DEPTH-entry compare table one
// entry per cycle through a single shared adder/comparator.

module adder_comparator #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   output logic             eq
);

   logic [WIDTH-1:0] sum;

   // Carry-out is dropped: the match is modulo 2^WIDTH.
   assign sum = a + b;
   assign eq  = (sum == c);

endmodule

module sum_match_scanner #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 8,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             inv_en,
   input  logic             clr_all,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_hit,
   output logic [IDX_W-1:0] rsp_idx
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SCAN = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

   logic [1:0]       state;
   logic [IDX_W-1:0] idx;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] tbl [DEPTH];
   logic [DEPTH-1:0] vld;
   logic [WIDTH-1:0] cur_c;
   logic             eq;
   logic             hit;

   for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      logic sel;

      assign sel = (wr_idx == IDX_W'(i));

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            tbl[i] <= '0;
            vld[i] <= 1'b0;
         end else begin
            if (wr_en && sel) begin
               tbl[i] <= wr_data;
            end
            // clr_all wins, but a same-cycle write still lands valid.
            if (clr_all) begin
               vld[i] <= wr_en && sel;
            end else if (wr_en && sel) begin
               vld[i] <= 1'b1;
            end else if (inv_en && sel) begin
               vld[i] <= 1'b0;
            end
         end
      end
   end

   assign cur_c = tbl[idx];

   adder_comparator #(
      .WIDTH (WIDTH)
   ) u_cmp (
      .a  (a_q),
      .b  (b_q),
      .c  (cur_c),
      .eq (eq)
   );

   assign hit = eq && vld[idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         idx     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         rsp_hit <= 1'b0;
         rsp_idx <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  a_q   <= req_a;
                  b_q   <= req_b;
                  idx   <= '0;
                  state <= SCAN;
               end
            end
            SCAN: begin
               if (hit) begin
                  rsp_hit <= 1'b1;
                  rsp_idx <= idx;
                  state   <= RESP;
               end else if (idx == LAST) begin
                  rsp_hit <= 1'b0;
                  rsp_idx <= '0;
                  state   <= RESP;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);

endmodule

// File: tb/tb_sum_match_scanner.sv
// Bench for sum_match_scanner: directed cases plus random table
// traffic and queries against a plain array model.

module tb_sum_match_scanner;

   localparam int W = 8;
   localparam int D = 8;
   localparam int IW = 3;

   logic          clk;
   logic          rst_n;
   logic          wr_en;
   logic [IW-1:0] wr_idx;
   logic [W-1:0]  wr_data;
   logic          inv_en;
   logic          clr_all;
   logic          req_valid;
   logic          req_ready;
   logic [W-1:0]  req_a;
   logic [W-1:0]  req_b;
   logic          rsp_valid;
   logic          rsp_ready;
   logic          rsp_hit;
   logic [IW-1:0] rsp_idx;

   int n_chk;
   int n_pass;

   logic [W-1:0] mtab [D];
   logic         mval [D];

   sum_match_scanner #(
      .WIDTH (W),
      .DEPTH (D)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_idx    (wr_idx),
      .wr_data   (wr_data),
      .inv_en    (inv_en),
      .clr_all   (clr_all),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_hit   (rsp_hit),
      .rsp_idx   (rsp_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Lowest valid entry equal to (a+b) mod 256, or -1.
   function automatic int model_find(input logic [W-1:0] a,
                                     input logic [W-1:0] b);
      logic [W-1:0] s;
      s = a + b;
      for (int i = 0; i < D; i++)
         if (mval[i] && mtab[i] == s) return i;
      return -1;
   endfunction

   task automatic model_clear_all();
      for (int i = 0; i < D; i++) begin
         mval[i] = 1'b0;
         mtab[i] = '0;
      end
   endtask

   task automatic wr(input int i, input logic [W-1:0] d);
      wr_en = 1'b1;
      wr_idx = IW'(i);
      wr_data = d;
      tick();
      wr_en = 1'b0;
      mtab[i] = d;
      mval[i] = 1'b1;
   endtask

   task automatic inv(input int i);
      inv_en = 1'b1;
      wr_idx = IW'(i);
      tick();
      inv_en = 1'b0;
      mval[i] = 1'b0;
   endtask

   task automatic clr(input bit with_wr, input int i,
                      input logic [W-1:0] d);
      clr_all = 1'b1;
      wr_en = with_wr;
      wr_idx = IW'(i);
      wr_data = d;
      tick();
      clr_all = 1'b0;
      wr_en = 1'b0;
      for (int j = 0; j < D; j++) mval[j] = 1'b0;
      if (with_wr) begin
         mtab[i] = d;
         mval[i] = 1'b1;
      end
   endtask

   // Returns offset from handshake cycle T to first rsp_valid cycle.
   task automatic wait_rsp(output int lat);
      lat = 1;
      while (!rsp_valid && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task automatic query(input string tag,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input bit ehit, input int eidx);
      int lat;
      req_valid = 1'b1;
      req_a = a;
      req_b = b;
      check({tag, ".rdy"}, 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
      check({tag, ".busy"}, 32'(req_ready), 32'd0);
      wait_rsp(lat);
      check({tag, ".lat"}, lat, ehit ? eidx + 2 : D + 1);
      check({tag, ".hit"}, 32'(rsp_hit), 32'(ehit));
      check({tag, ".idx"}, 32'(rsp_idx), ehit ? eidx : 0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   initial begin
      int lat;
      int k;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      n_chk = 0;
      n_pass = 0;
      rst_n = 1'b0;
      wr_en = 1'b0;
      wr_idx = '0;
      wr_data = '0;
      inv_en = 1'b0;
      clr_all = 1'b0;
      req_valid = 1'b0;
      req_a = '0;
      req_b = '0;
      rsp_ready = 1'b0;
      model_clear_all();
      tick();
      tick();
      check("rst.req_ready", 32'(req_ready), 32'd1);
      check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst.rsp_hit", 32'(rsp_hit), 32'd0);
      check("rst.rsp_idx", 32'(rsp_idx), 32'd0);
      rst_n = 1'b1;
      tick();

      query("empty", 8'h10, 8'h20, 1'b0, 0);

      wr(5, 8'h30);
      wr(2, 8'h30);
      query("lowest", 8'h10, 8'h20, 1'b1, 2);

      wr(0, 8'h10);
      query("wrap", 8'hF0, 8'h20, 1'b1, 0);

      // Stall the response and keep a new request pending.
      req_valid = 1'b1;
      req_a = 8'h30;
      req_b = 8'h00;
      tick();
      req_a = 8'hAA;
      wait_rsp(lat);
      check("stall.lat", lat, 32'd4);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall.valid", 32'(rsp_valid), 32'd1);
         check("stall.hit", 32'(rsp_hit), 32'd1);
         check("stall.idx", 32'(rsp_idx), 32'd2);
         check("stall.rdy", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      req_valid = 1'b0;
      query("after_stall", 8'hF0, 8'h20, 1'b1, 0);

      // Write during scan: entry 6 filled while idx=3, entry 1 dropped at idx=2.
      clr(1'b0, 0, 8'h00);
      wr(1, 8'h07);
      wr(3, 8'h09);
      req_valid = 1'b1;
      req_a = 8'h01;
      req_b = 8'h02;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      inv_en = 1'b1;
      wr_idx = 3'd1;
      tick();
      inv_en = 1'b0;
      wr_en = 1'b1;
      wr_idx = 3'd6;
      wr_data = 8'h03;
      tick();
      wr_en = 1'b0;
      mval[1] = 1'b0;
      mtab[6] = 8'h03;
      mval[6] = 1'b1;
      wait_rsp(lat);
      check("midwr.lat", lat + 4, 32'd8);
      check("midwr.hit", 32'(rsp_hit), 32'd1);
      check("midwr.idx", 32'(rsp_idx), 32'd6);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // Clear-all with a simultaneous write keeps only the written entry.
      wr(0, 8'h44);
      wr(2, 8'h44);
      clr(1'b1, 4, 8'h44);
      query("clrwr", 8'h40, 8'h04, 1'b1, 4);
      query("clrwr.old", 8'h01, 8'h06, 1'b0, 0);

      // Reset mid-scan.
      wr(7, 8'h55);
      req_valid = 1'b1;
      req_a = 8'h50;
      req_b = 8'h05;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("mrst.req_ready", 32'(req_ready), 32'd1);
      check("mrst.rsp_valid", 32'(rsp_valid), 32'd0);
      check("mrst.rsp_hit", 32'(rsp_hit), 32'd0);
      check("mrst.rsp_idx", 32'(rsp_idx), 32'd0);
      model_clear_all();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("mrst.norsp", 32'(rsp_valid), 32'd0);
      end
      query("mrst.miss", 8'h50, 8'h05, 1'b0, 0);
      query("mrst.zero", 8'h00, 8'h00, 1'b0, 0);

      // Random table traffic and queries against the model.
      for (int it = 0; it < 60; it++) begin
         for (int n = 0; n < 3; n++) begin
            k = $urandom_range(0, 9);
            if (k <= 5)
               wr($urandom_range(0, D - 1), W'($urandom_range(0, 15)));
            else if (k <= 7)
               inv($urandom_range(0, D - 1));
            else if (k == 8 && $urandom_range(0, 3) == 0)
               clr(1'b0, 0, 8'h00);
            else if (k == 9)
               clr(1'b1, $urandom_range(0, D - 1),
                   W'($urandom_range(0, 15)));
         end
         ra = W'($urandom);
         rb = W'($urandom_range(0, 15)) - ra;
         k = model_find(ra, rb);
         query("rand", ra, rb, k >= 0, k >= 0 ? k : 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
